// File: rtl/controle_unit.sv
// Instruction decoder: turns one 32-bit instruction into a packed control
// word, registered with one cycle of latency.
module controle_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   output logic [31:0] output_controle
);

   localparam logic [5:0]  OP_LOAD   = 6'b000110;
   localparam logic [5:0]  OP_ALU    = 6'b000101;
   localparam logic [5:0]  FUNCT_ALU = 6'b100000;
   localparam logic [31:0] WORD_ILL  = 32'h4000_0000;

   logic [5:0]  opcode;
   logic [4:0]  field_a;
   logic [4:0]  src_a;
   logic [4:0]  src_b;
   logic [4:0]  alu_dst;
   logic [5:0]  funct;
   logic [15:0] imm;

   assign opcode  = instruction[31:26];
   assign field_a = instruction[25:21];
   assign src_a   = instruction[20:16];
   assign src_b   = instruction[15:11];
   assign alu_dst = instruction[10:6];
   assign funct   = instruction[5:0];
   assign imm     = instruction[15:0];

   logic [2:0]  alu_op;
   logic        alu_sel_ok;
   logic        is_load;
   logic        is_alu;
   logic [31:0] ctrl_d;
   logic [31:0] ctrl_q;

   always_comb begin
      alu_op     = 3'b000;
      alu_sel_ok = 1'b1;
      case (field_a)
         5'b00100: alu_op = 3'b001;
         5'b00101: alu_op = 3'b010;
         5'b00110: alu_op = 3'b011;
         5'b00111: alu_op = 3'b100;
         5'b01000: alu_op = 3'b101;
         default:  alu_sel_ok = 1'b0;
      endcase
   end

   assign is_load = (opcode == OP_LOAD);
   assign is_alu  = (opcode == OP_ALU) && (funct == FUNCT_ALU)
                    && alu_sel_ok;

   // Word layout: valid, illegal, reg_write, imm_sel, alu_op, 4'b0, dest, operands
   always_comb begin
      ctrl_d = WORD_ILL;
      unique case (1'b1)
         is_load: ctrl_d = {1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 4'b0000,
                            field_a, imm};
         is_alu:  ctrl_d = {1'b1, 1'b0, 1'b1, 1'b0, alu_op, 4'b0000,
                            alu_dst, src_a, src_b, 6'b000000};
         default: ctrl_d = WORD_ILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= 32'h0000_0000;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign output_controle = ctrl_q;

endmodule

// File: tb/tb_controle_unit.sv
// Bench for controle_unit: directed vector table, hand-written timing
// sequences and random instructions against an arithmetic reference model.
module tb_controle_unit;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] output_controle;

   int checks;
   int failures;

   controle_unit dut (
      .clk             (clk),
      .rst             (rst),
      .instruction     (instruction),
      .output_controle (output_controle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] expect_word;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %08h want %08h", name, got, want);
      end
   endtask

   // Reference decode computed from the field rules with plain arithmetic
   function automatic logic [31:0] model(input logic [31:0] i);
      int unsigned op, dst, sel, fn, sa, sb, ad, aop;
      op  = i >> 26;
      dst = (i >> 21) & 31;
      sa  = (i >> 16) & 31;
      sb  = (i >> 11) & 31;
      ad  = (i >> 6) & 31;
      fn  = i & 63;
      sel = dst;
      if (op == 6)
         return 32'hB000_0000 + (dst << 16) + (i & 32'hFFFF);
      if (op == 5 && fn == 32 && sel >= 4 && sel <= 8) begin
         aop = sel - 3;
         return 32'hA000_0000 + (aop << 25) + (ad << 16)
                + (sa << 11) + (sb << 6);
      end
      return 32'h4000_0000;
   endfunction

   task automatic apply_and_check(input string name, input logic [31:0] ins,
                                  input logic [31:0] want);
      @(negedge clk);
      instruction = ins;
      @(posedge clk);
      #1;
      check(name, output_controle, want);
   endtask

   initial begin
      logic [31:0] r;
      int unsigned kind;
      checks   = 0;
      failures = 0;

      vecs.push_back('{"load_a",    32'h1807_0000, 32'hB000_0000});
      vecs.push_back('{"load_b",    32'h1827_0001, 32'hB001_0001});
      vecs.push_back('{"add",       32'h1480_0AA0, 32'hA20A_0040});
      vecs.push_back('{"sub",       32'h14A2_1AA0, 32'hA40A_10C0});
      vecs.push_back('{"bad_funct", 32'h1480_0AA1, 32'h4000_0000});
      vecs.push_back('{"bad_sel",   32'h1460_0AA0, 32'h4000_0000});
      vecs.push_back('{"op_zero",   32'h0000_0000, 32'h4000_0000});
      vecs.push_back('{"op_ones",   32'hFC00_0000, 32'h4000_0000});
      vecs.push_back('{"and",       32'h14C0_0AA0, 32'hA60A_0040});
      vecs.push_back('{"or",        32'h14E0_0AA0, 32'hA80A_0040});
      vecs.push_back('{"xor",       32'h1500_0AA0, 32'hAA0A_0040});
      vecs.push_back('{"sel_9",     32'h1520_0AA0, 32'h4000_0000});
      vecs.push_back('{"load_max",  32'h1BFF_FFFF, 32'hB01F_FFFF});

      // Asynchronous reset before any clock edge
      rst = 1'b1;
      instruction = 32'h1807_0000;
      #3;
      check("reset_async", output_controle, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("reset_held", output_controle, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_release_no_edge", output_controle, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("first_edge", output_controle, 32'hB000_0000);

      foreach (vecs[k]) begin
         apply_and_check(vecs[k].name, vecs[k].instr, vecs[k].expect_word);
         check({vecs[k].name, "_model"}, model(vecs[k].instr),
               vecs[k].expect_word);
      end

      // Back-to-back pipelining and mid-cycle input changes
      apply_and_check("pipe_add", 32'h1480_0AA0, 32'hA20A_0040);
      #2;
      instruction = 32'h14A2_1AA0;
      #1;
      check("hold_between_edges", output_controle, 32'hA20A_0040);
      @(posedge clk);
      #1;
      check("pipe_sub", output_controle, 32'hA40A_10C0);
      instruction = 32'hFC00_0000;
      #2;
      instruction = 32'h1827_0001;
      @(posedge clk);
      #1;
      check("last_value_sampled", output_controle, 32'hB001_0001);

      // Mid-stream reset pulse between edges
      instruction = 32'h1480_0AA0;
      #1;
      rst = 1'b1;
      #1;
      check("midstream_reset", output_controle, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      instruction = 32'h14A2_1AA0;
      #1;
      check("midstream_discarded", output_controle, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("after_midstream_reset", output_controle, 32'hA40A_10C0);

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 3);
         r = $urandom;
         case (kind)
            0: ;
            1: r[31:26] = 6'b000110;
            2: begin
               r[31:26] = 6'b000101;
               r[25:21] = 5'($urandom_range(0, 10));
               r[5:0]   = 6'b100000;
            end
            default: r[31:26] = 6'b000101;
         endcase
         apply_and_check("random", r, model(r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
